// File: rtl/timer_unit.sv
// Memory-mapped programmable timer: prescaler, 64-bit mtime/compare, one-shot or periodic
// matching, sticky pending/overrun status and a one-cycle i_timer pulse.
module timer_unit #(
    parameter int unsigned PRESCALE_W   = 16,
    parameter int unsigned PRESCALE_RST = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    output logic        i_timer,
    output logic        tick
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_MTIME_LO = 3'd2;
    localparam logic [2:0] REG_MTIME_HI = 3'd3;
    localparam logic [2:0] REG_CMP_LO   = 3'd4;
    localparam logic [2:0] REG_CMP_HI   = 3'd5;
    localparam logic [2:0] REG_STATUS   = 3'd6;

    logic                  en_q, en_d;
    logic                  periodic_q, periodic_d;
    logic                  irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           cmp_q, cmp_d;
    logic                  pending_q, pending_d;
    logic                  overrun_q, overrun_d;
    logic                  i_timer_q, i_timer_d;
    logic                  tick_q, tick_d;

    logic        wr_ctrl, wr_prescale, wr_mtime_lo, wr_mtime_hi;
    logic        wr_cmp_lo, wr_cmp_hi, wr_status;
    logic        tick_int, per_hit, match;
    logic [63:0] mtime_inc, mtime_tick;

    assign wr_ctrl     = we && (a == REG_CTRL);
    assign wr_prescale = we && (a == REG_PRESCALE);
    assign wr_mtime_lo = we && (a == REG_MTIME_LO);
    assign wr_mtime_hi = we && (a == REG_MTIME_HI);
    assign wr_cmp_lo   = we && (a == REG_CMP_LO);
    assign wr_cmp_hi   = we && (a == REG_CMP_HI);
    assign wr_status   = we && (a == REG_STATUS);

    assign tick_int   = en_q && (psc_cnt_q == prescale_q);
    assign mtime_inc  = mtime_q + 64'd1;
    assign per_hit    = periodic_q && (mtime_q >= cmp_q);
    assign match      = tick_int && (periodic_q ? per_hit : (mtime_inc == cmp_q));
    assign mtime_tick = per_hit ? 64'd0 : mtime_inc;

    always_comb begin
        // With en low the count already sits at 0, so an en 0->1 write starts a fresh period.
        if (!en_q || tick_int) begin
            psc_cnt_d = '0;
        end else begin
            psc_cnt_d = psc_cnt_q + PRESCALE_W'(1);
        end

        mtime_d = mtime_q;
        if (tick_int) begin
            mtime_d[31:0]  = mtime_tick[31:0];
            mtime_d[63:32] = (wr_mtime_lo && !per_hit) ? mtime_q[63:32] : mtime_tick[63:32];
        end
        if (wr_mtime_lo) begin
            mtime_d[31:0] = d;
        end
        if (wr_mtime_hi) begin
            mtime_d[63:32] = d;
        end

        // Compare writes land next cycle; the match above already used the old value.
        cmp_d = cmp_q;
        if (wr_cmp_lo) begin
            cmp_d[31:0] = d;
        end
        if (wr_cmp_hi) begin
            cmp_d[63:32] = d;
        end

        en_d       = (match && !periodic_q) ? 1'b0 : en_q;
        periodic_d = periodic_q;
        irq_en_d   = irq_en_q;
        if (wr_ctrl) begin
            en_d       = d[0];
            periodic_d = d[1];
            irq_en_d   = d[2];
        end

        prescale_d = wr_prescale ? d[PRESCALE_W-1:0] : prescale_q;

        pending_d = match || (pending_q && !(wr_status && d[0]));
        overrun_d = (match && pending_q) || (overrun_q && !(wr_status && d[1]));
        i_timer_d = match && irq_en_q;
        tick_d    = tick_int;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= PRESCALE_W'(PRESCALE_RST);
            psc_cnt_q  <= '0;
            mtime_q    <= 64'd0;
            cmp_q      <= 64'hFFFF_FFFF_FFFF_FFFF;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            i_timer_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
            mtime_q    <= mtime_d;
            cmp_q      <= cmp_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            i_timer_q  <= i_timer_d;
            tick_q     <= tick_d;
        end
    end

    always_comb begin
        case (a)
            REG_CTRL:     spo = {29'd0, irq_en_q, periodic_q, en_q};
            REG_PRESCALE: spo = 32'(prescale_q);
            REG_MTIME_LO: spo = mtime_q[31:0];
            REG_MTIME_HI: spo = mtime_q[63:32];
            REG_CMP_LO:   spo = cmp_q[31:0];
            REG_CMP_HI:   spo = cmp_q[63:32];
            REG_STATUS:   spo = {30'd0, overrun_q, pending_q};
            default:      spo = 32'd0;
        endcase
    end

    assign i_timer = i_timer_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_timer_unit.sv
// Bench for timer_unit: directed scenarios plus random bus traffic, each cycle's expected
// outputs queued by the driver and compared by an independent negedge monitor.
module tb_timer_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  a;
    logic [31:0] d;
    logic        we;
    logic [31:0] spo;
    logic        i_timer;
    logic        tick;

    int checks   = 0;
    int failures = 0;

    timer_unit #(.PRESCALE_W(16), .PRESCALE_RST(0)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we),
        .spo(spo), .i_timer(i_timer), .tick(tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] spo;
        logic        irq;
        logic        tck;
    } exp_t;
    exp_t sb[$];

    // Reference model state, kept as plain register-level values
    bit          m_en, m_per, m_irqen, m_pend, m_ovr, m_irq, m_tick;
    logic [15:0] m_psc, m_pcnt;
    logic [63:0] m_mtime, m_cmp;

    task automatic m_reset();
        m_en = 0; m_per = 0; m_irqen = 0; m_pend = 0; m_ovr = 0; m_irq = 0; m_tick = 0;
        m_psc = 16'd0; m_pcnt = 16'd0; m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] ad);
        case (ad)
            3'd0: return {29'd0, m_irqen, m_per, m_en};
            3'd1: return {16'd0, m_psc};
            3'd2: return m_mtime[31:0];
            3'd3: return m_mtime[63:32];
            3'd4: return m_cmp[31:0];
            3'd5: return m_cmp[63:32];
            3'd6: return {30'd0, m_ovr, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the timer, written from the register-map rules
    task automatic m_step(input logic w, input logic [2:0] ad, input logic [31:0] dd);
        bit          fire, hit, prev_pend;
        logic [63:0] old_t, nt;
        fire  = m_en && (m_pcnt == m_psc);
        hit   = 0;
        old_t = m_mtime;
        nt    = m_mtime;
        if (fire) begin
            if (m_per) begin
                if (m_mtime >= m_cmp) begin nt = 64'd0; hit = 1; end
                else nt = m_mtime + 64'd1;
            end else begin
                nt  = m_mtime + 64'd1;
                hit = (nt == m_cmp);
            end
        end
        m_tick = fire;
        m_irq  = hit && m_irqen;
        m_pcnt = (!m_en || fire) ? 16'd0 : m_pcnt + 16'd1;
        if (hit && !m_per) m_en = 0;
        prev_pend = m_pend;
        if (w && ad == 3'd6) begin
            if (dd[0]) m_pend = 0;
            if (dd[1]) m_ovr  = 0;
        end
        if (hit) begin
            m_pend = 1;
            if (prev_pend) m_ovr = 1;
        end
        m_mtime = nt;
        if (w) begin
            case (ad)
                3'd0: begin m_en = dd[0]; m_per = dd[1]; m_irqen = dd[2]; end
                3'd1: m_psc = dd[15:0];
                3'd2: m_mtime = {(fire && hit && m_per) ? 32'd0 : old_t[63:32], dd};
                3'd3: m_mtime[63:32] = dd;
                3'd4: m_cmp[31:0] = dd;
                3'd5: m_cmp[63:32] = dd;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // irq_mode: 0 = take i_timer from the model, 1 = require 0, 2 = require 1
    task automatic step(input logic w, input logic [2:0] ad, input logic [31:0] dd,
                        input bit use_c, input logic [31:0] c_spo, input int irq_mode);
        exp_t e;
        we = w; a = ad; d = dd;
        e.a   = ad;
        e.spo = use_c ? c_spo : m_read(ad);
        e.irq = (irq_mode == 0) ? m_irq : (irq_mode == 2);
        e.tck = m_tick;
        sb.push_back(e);
        @(posedge clk);
        m_step(w, ad, dd);
        #1;
    endtask

    task automatic wr(input logic [2:0] ad, input logic [31:0] dd);
        step(1'b1, ad, dd, 1'b0, 32'd0, 0);
    endtask
    task automatic rd(input logic [2:0] ad);
        step(1'b0, ad, 32'd0, 1'b0, 32'd0, 0);
    endtask
    task automatic rdc(input logic [2:0] ad, input logic [31:0] exp);
        step(1'b0, ad, 32'd0, 1'b1, exp, 0);
    endtask

    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                chk($sformatf("spo[a=%0d]", cur.a), spo, cur.spo);
                chk("i_timer", {31'd0, i_timer}, {31'd0, cur.irq});
                chk("tick", {31'd0, tick}, {31'd0, cur.tck});
            end
        end
    end

    task automatic rand_phase(input int n);
        logic [2:0]  ad;
        logic [31:0] dd;
        int          r;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 99);
            ad = 3'($urandom_range(0, 7));
            if (r < 25) begin
                case (ad)
                    3'd0: dd = $urandom;
                    3'd1: dd = $urandom & 32'hFFFF_0003;
                    3'd2: dd = (r % 2 == 1) ? 32'($urandom_range(0, 8)) : (32'hFFFF_FFF0 | ($urandom & 32'hF));
                    3'd3: dd = (r < 5) ? 32'hFFFF_FFFF : 32'h0;
                    3'd4: dd = 32'($urandom_range(0, 12));
                    3'd5: dd = (r < 3) ? 32'h1 : 32'h0;
                    3'd6: dd = $urandom & 32'h3;
                    default: dd = $urandom;
                endcase
                wr(ad, dd);
            end else begin
                rd(ad);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; a = 3'd0; d = 32'd0;
        m_reset();
        #22 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset values of every index
        rdc(3'd0, 32'd0);          rdc(3'd1, 32'd0);
        rdc(3'd2, 32'd0);          rdc(3'd3, 32'd0);
        rdc(3'd4, 32'hFFFF_FFFF);  rdc(3'd5, 32'hFFFF_FFFF);
        rdc(3'd6, 32'd0);          rdc(3'd7, 32'd0);

        // One-shot: prescale 3, cmp 5 -> pulse 20 clocks after the CTRL write
        wr(3'd1, 32'd3); wr(3'd4, 32'd5); wr(3'd5, 32'd0);
        wr(3'd0, 32'h5);
        for (int j = 1; j <= 25; j++) step(1'b0, 3'd2, 32'd0, 1'b0, 32'd0, (j == 21) ? 2 : 1);
        rdc(3'd2, 32'd5); rdc(3'd0, 32'h4); rdc(3'd6, 32'h1);
        wr(3'd6, 32'h3); rdc(3'd6, 32'h0);

        // Periodic: prescale 0, cmp 2 -> mtime 0,1,2,0 and a pulse every 3 clocks
        wr(3'd0, 32'd0); wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd1, 32'd0);
        wr(3'd5, 32'd0); wr(3'd4, 32'd2);
        wr(3'd0, 32'h7);
        for (int j = 1; j <= 9; j++)
            step(1'b0, 3'd2, 32'd0, 1'b1, 32'((j - 1) % 3), (j >= 4 && (j - 1) % 3 == 0) ? 2 : 1);
        wr(3'd0, 32'd0);
        rdc(3'd6, 32'h3); wr(3'd6, 32'h3); rdc(3'd6, 32'h0);

        // Carry from LO into HI in one-shot mode, cmp = 1/0
        wr(3'd1, 32'd0); wr(3'd4, 32'd0); wr(3'd5, 32'd1);
        wr(3'd2, 32'hFFFF_FFFE); wr(3'd3, 32'd0);
        wr(3'd0, 32'h5);
        rdc(3'd3, 32'd0); rdc(3'd2, 32'hFFFF_FFFF); rdc(3'd3, 32'd1);
        rdc(3'd2, 32'd0); rdc(3'd6, 32'h1); rdc(3'd0, 32'h4);
        wr(3'd6, 32'h3);

        // STATUS clear landing exactly on a periodic match: set wins, no overrun
        wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd5, 32'd0); wr(3'd4, 32'd2); wr(3'd1, 32'd0);
        wr(3'd0, 32'h3);
        rd(3'd2); rd(3'd2);
        wr(3'd6, 32'h1);
        rdc(3'd6, 32'h1);
        wr(3'd0, 32'd0); wr(3'd6, 32'h3);

        rand_phase(700);

        // Asynchronous reset in the middle of a periodic run
        wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd5, 32'd0); wr(3'd4, 32'd7);
        wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd0, 32'h7);
        for (int j = 0; j < 10; j++) rd(3'd2);
        we = 1'b0; a = 3'd0;
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("async_rst i_timer", {31'd0, i_timer}, 32'd0);
        chk("async_rst tick", {31'd0, tick}, 32'd0);
        chk("async_rst ctrl", spo, 32'd0);
        a = 3'd2;
        #2;
        chk("async_rst mtime_lo", spo, 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int j = 0; j < 8; j++) rdc(3'd2, 32'd0);
        rdc(3'd0, 32'd0);
        wr(3'd0, 32'h1);
        for (int j = 0; j < 6; j++) rd(3'd2);

        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
